// File: rtl/timer_clock_pkg.sv
// Shared types and constants for the MM:SS timer: mode encoding, wrap limit
// and the active-low 7-segment patterns ({g,f,e,d,c,b,a}).
package timer_clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_SET   = 2'd2
    } mode_e;

    localparam int MAX_MS = 59;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Entry k is the pattern for digit k.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg7_of(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

endpackage

// File: rtl/timer_clock_seg7_scan.sv
// Multiplexed 4-digit 7-segment driver: one digit lit per SCAN_DIV cycles,
// registered outputs, everything dark and the scan frozen while blanked.
module seg7_scan
    import timer_clock_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blank_i,
    input  logic [15:0] digits_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (!blank_i) begin
            if (div_q == CW'(SCAN_DIV - 1)) begin
                div_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // digits_i[4k +: 4] belongs to anode k.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = SEG_BLANK;
        if (!blank_i) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg7_of(digits_i[{idx_q, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= 4'b1111;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg_o = seg_q;
    assign an_o  = an_q;

endmodule

// File: rtl/timer_clock.sv
// MM:SS stopwatch with run/pause/set modes, button conditioning, power-down
// blanking and a multiplexed 7-segment display.
module timer_clock
    import timer_clock_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_resume,
    input  logic       set_time_mode,
    input  logic [3:0] set_buttons,
    input  logic       power_switch,
    output logic [6:0] disp_seg_o,
    output logic [3:0] disp_an_o,
    output logic       led_state
);

    localparam int NBTN = 6;
    localparam int PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int DW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [NBTN-1:0] btn_raw, btn_meta_q, btn_sync_q, btn_pulse;
    logic [1:0]      pwr_sync_q;
    logic            pwr_down;

    // Bit order: {sec+1, min+1, mode, pause, set_time_mode, pause_resume}.
    assign btn_raw  = {set_buttons, set_time_mode, pause_resume};
    assign pwr_down = pwr_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            pwr_sync_q <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            pwr_sync_q <= {pwr_sync_q[0], power_switch};
        end
    end

    for (genvar g = 0; g < NBTN; g++) begin : g_deb
        logic [DW-1:0] cnt_q, cnt_d;
        logic          lvl_q, lvl_d, prev_q;

        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (btn_sync_q[g] != lvl_q) begin
                if (cnt_q == DW'(DEB_CYCLES - 1)) lvl_d = btn_sync_q[g];
                else                              cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                lvl_q  <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                lvl_q  <= lvl_d;
                prev_q <= lvl_q;
            end
        end

        assign btn_pulse[g] = lvl_q & ~prev_q;
    end

    logic pause_ev, mode_ev, min_ev, sec_ev;

    assign pause_ev = (btn_pulse[0] | btn_pulse[2]) & ~pwr_down;
    assign mode_ev  = (btn_pulse[1] | btn_pulse[3]) & ~pwr_down;
    assign min_ev   = btn_pulse[4] & ~pwr_down;
    assign sec_ev   = btn_pulse[5] & ~pwr_down;

    mode_e mode_q, mode_d;
    logic  led_d, counting, set_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode_q <= MODE_RUN;
        else     mode_q <= mode_d;
    end

    // A mode event wins over a pause event arriving in the same cycle.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN: begin
                if (mode_ev)       mode_d = MODE_SET;
                else if (pause_ev) mode_d = MODE_PAUSE;
            end
            MODE_PAUSE: begin
                if (mode_ev)       mode_d = MODE_SET;
                else if (pause_ev) mode_d = MODE_RUN;
            end
            MODE_SET: begin
                if (mode_ev) mode_d = MODE_RUN;
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    always_comb begin
        led_d     = (mode_d == MODE_RUN) && !pwr_down;
        counting  = (mode_q == MODE_RUN) && !pwr_down;
        set_entry = (mode_d == MODE_SET) && (mode_q != MODE_SET);
    end

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d, min_q, min_d;
    logic          tick, led_q;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (counting) begin
            if (presc_q == PW'(CLK_FREQ - 1)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (set_entry) presc_d = '0;
    end

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        if (tick) begin
            if (sec_q == 6'(MAX_MS)) begin
                sec_d = '0;
                min_d = (min_q == 6'(MAX_MS)) ? 6'd0 : min_q + 6'd1;
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (mode_q == MODE_SET) begin
            if (min_ev) min_d = (min_q == 6'(MAX_MS)) ? 6'd0 : min_q + 6'd1;
            if (sec_ev) sec_d = (sec_q == 6'(MAX_MS)) ? 6'd0 : sec_q + 6'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            led_q   <= led_d;
        end
    end

    assign led_state = led_q;

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .blank_i  (pwr_down),
        .digits_i ({bcd_tens(min_q), bcd_ones(min_q), bcd_tens(sec_q), bcd_ones(sec_q)}),
        .seg_o    (disp_seg_o),
        .an_o     (disp_an_o)
    );

endmodule

// File: tb/tb_timer_clock.sv
// Directed-with-random-lengths bench for timer_clock; time is modelled as a
// count of running clock edges folded into seconds modulo one hour.
module tb_timer_clock;

  localparam int CLK_FREQ   = 10;
  localparam int SCAN_DIV   = 2;
  localparam int DEB_CYCLES = 4;
  // Press -> effect: two synchronizer flops, the stability filter, then the edge register.
  localparam int EV_LAT     = 2 + DEB_CYCLES + 1;
  localparam int HOLD       = 10;
  localparam int M_RUN = 0, M_PAUSE = 1, M_SET = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause_resume = 1'b0;
  logic       set_time_mode = 1'b0;
  logic [3:0] set_buttons = 4'd0;
  logic       power_switch = 1'b0;
  logic [6:0] disp_seg_o;
  logic [3:0] disp_an_o;
  logic       led_state;

  timer_clock #(
    .CLK_FREQ(CLK_FREQ),
    .SCAN_DIV(SCAN_DIV),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pause_resume (pause_resume),
    .set_time_mode(set_time_mode),
    .set_buttons  (set_buttons),
    .power_switch (power_switch),
    .disp_seg_o   (disp_seg_o),
    .disp_an_o    (disp_an_o),
    .led_state    (led_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_min, m_sec, m_cnt, m_mode, pd_cd;
  bit m_pd;
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_cnt = 0; m_mode = M_RUN; m_pd = 0; pd_cd = 0;
  endtask

  task automatic model_second();
    int t;
    t = (m_min * 60 + m_sec + 1) % 3600;
    m_min = t / 60;
    m_sec = t % 60;
  endtask

  // ev bits: {sec+1, min+1, set_buttons[1], set_buttons[0], set_time_mode, pause_resume}
  task automatic model_events(input logic [5:0] ev);
    int prev;
    prev = m_mode;
    if (prev == M_SET) begin
      if (ev[4]) m_min = (m_min + 1) % 60;
      if (ev[5]) m_sec = (m_sec + 1) % 60;
    end
    if (ev[1] | ev[3]) m_mode = (prev == M_SET) ? M_RUN : M_SET;
    else if ((ev[0] | ev[2]) && prev != M_SET) m_mode = (prev == M_RUN) ? M_PAUSE : M_RUN;
    if (m_mode == M_SET && prev != M_SET) m_cnt = 0;
  endtask

  task automatic step(input logic [5:0] ev);
    @(posedge clk);
    if (m_mode == M_RUN && !m_pd) begin
      m_cnt++;
      if (m_cnt == CLK_FREQ) begin
        m_cnt = 0;
        model_second();
      end
    end
    if (!m_pd && ev != 6'd0) model_events(ev);
    if (pd_cd > 0) begin
      pd_cd--;
      if (pd_cd == 0) m_pd = power_switch;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(6'd0);
  endtask

  task automatic press(input logic [5:0] b);
    {set_buttons, set_time_mode, pause_resume} = b;
    for (int i = 1; i <= HOLD; i++) step((i == EV_LAT) ? b : 6'd0);
    {set_buttons, set_time_mode, pause_resume} = 6'd0;
    for (int i = 0; i < HOLD; i++) step(6'd0);
  endtask

  task automatic set_power(input logic v);
    power_switch = v;
    pd_cd = 2;
    for (int i = 0; i < 4; i++) step(6'd0);
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hE;
    endcase
  endfunction

  // Reads all four digits off the scanned display; only valid while time is frozen.
  task automatic check_time(input string tag);
    logic [15:0] obs;
    int bad;
    obs = 16'hEEEE;
    bad = 0;
    exp_q.push_back({4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)});
    for (int i = 0; i < 4 * SCAN_DIV + 2; i++) begin
      case (disp_an_o)
        4'b1110: obs[3:0]   = seg2dig(disp_seg_o);
        4'b1101: obs[7:4]   = seg2dig(disp_seg_o);
        4'b1011: obs[11:8]  = seg2dig(disp_seg_o);
        4'b0111: obs[15:12] = seg2dig(disp_seg_o);
        default: bad++;
      endcase
      step(6'd0);
    end
    check({tag, "_anode_onehot"}, 32'(bad), 32'd0);
    check({tag, "_mmss"}, {16'd0, obs}, {16'd0, exp_q.pop_front()});
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_an"}, {28'd0, disp_an_o}, 32'hF);
    check({tag, "_seg"}, {25'd0, disp_seg_o}, 32'h7F);
    check({tag, "_led"}, {31'd0, led_state}, 32'd0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_blank("reset_init");
    rst = 1'b0;

    // Reset asserted mid-count around 00:37
    run(370 + $urandom_range(0, 5));
    #2 rst = 1'b1;
    #1 check_blank("reset_midcount");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(3);
    check("led_after_reset", {31'd0, led_state}, 32'd1);
    check("scan_onehot", 32'($countones(~disp_an_o)), 32'd1);

    // 600 running edges -> 01:00, frozen by a pause press timed to land on edge 600
    run(600 - 3 - EV_LAT);
    press(6'b000100);
    check("led_paused", {31'd0, led_state}, 32'd0);
    check_time("run_600");
    for (int i = 0; i < 4 * SCAN_DIV + 2 && disp_an_o != 4'b1011; i++) step(6'd0);
    check("an_min_ones", {28'd0, disp_an_o}, 32'hB);
    check("seg_min_ones_1", {25'd0, disp_seg_o}, {25'd0, 7'b1111001});
    for (int i = 0; i < 4 * SCAN_DIV + 2 && disp_an_o != 4'b1110; i++) step(6'd0);
    check("an_sec_ones", {28'd0, disp_an_o}, 32'hE);
    check("seg_sec_ones_0", {25'd0, disp_seg_o}, {25'd0, 7'b1000000});

    run(200);
    check_time("pause_frozen");
    press(6'b000001);
    check("led_resumed", {31'd0, led_state}, 32'd1);

    // Random run lengths exercise the retained partial prescaler count
    for (int k = 0; k < 4; k++) begin
      run($urandom_range(3, 40));
      if (k == 2) press(6'b000101);
      else        press((k % 2 == 0) ? 6'b000100 : 6'b000001);
      check("led_rand_pause", {31'd0, led_state}, 32'd0);
      check_time("rand_pause");
      press(6'b000001);
      check("led_rand_run", {31'd0, led_state}, 32'd1);
    end

    // Increments outside SET are ignored
    press(6'b000001);
    press(6'b110000);
    check_time("inc_ignored_pause");

    // SET mode
    press(6'b001000);
    check("led_set", {31'd0, led_state}, 32'd0);
    press(6'b010000);
    press(6'b100000);
    check_time("set_min_sec");
    press(6'b110000);
    check_time("set_both");
    press(6'b000001);
    check_time("set_pause_ignored");
    check("led_set_pause_ignored", {31'd0, led_state}, 32'd0);
    while (m_sec != 59) press(6'b100000);
    check_time("set_sec59");
    press(6'b100000);
    check_time("set_sec_wrap");
    press(6'b000010);
    check("led_set_exit", {31'd0, led_state}, 32'd1);

    // 59:59 wraps through 00:00
    press(6'b001000);
    while (m_min != 59) press(6'b010000);
    while (m_sec != 59) press(6'b100000);
    check_time("preset_5959");
    press(6'b000010);
    press(6'b000001);
    check_time("wrap");

    // Power down while running
    press(6'b000001);
    run($urandom_range(5, 30));
    set_power(1'b1);
    run(20);
    check_blank("pd_run");
    press(6'b000001);
    press(6'b000010);
    press(6'b110000);
    run(50);
    check_blank("pd_buttons");
    set_power(1'b0);
    run(3);
    check("led_pd_restore", {31'd0, led_state}, 32'd1);
    run($urandom_range(5, 30));
    press(6'b000100);
    check_time("pd_resume");

    // Power down while paused keeps the displayed time
    set_power(1'b1);
    run(30);
    check_blank("pd_pause");
    set_power(1'b0);
    run(5);
    check("led_pd_pause", {31'd0, led_state}, 32'd0);
    check_time("pd_pause_restore");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
